// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters share one UART transmitter.
// A winner's byte is latched on grant; completion is a fresh rising edge of i_tx_done.
module uart_tx_arbiter #(
  parameter int DATA_SIZE = 8,
  parameter int N_REQ     = 4,
  parameter int TIMEOUT   = 1023
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [N_REQ-1:0]           i_req,
  input  logic [N_REQ*DATA_SIZE-1:0] i_data,
  input  logic                       i_tx_active,
  input  logic                       i_tx_done,
  output logic                       o_tx_start,
  output logic [DATA_SIZE-1:0]       o_tx_data,
  output logic [N_REQ-1:0]           o_grant,
  output logic [N_REQ-1:0]           o_ack,
  output logic                       o_timeout,
  output logic                       o_busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    SEND    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   owner;
  logic [CNT_W-1:0]   cnt;
  logic               done_prev;
  logic               done_rise;

  logic [PTR_W:0]       shift_amt;
  logic [N_REQ-1:0]     req_rot;
  logic [PTR_W-1:0]     rot_off;
  logic [PTR_W:0]       win_sum;
  logic [PTR_W-1:0]     win_idx;
  logic [N_REQ-1:0]     win_onehot;
  logic [DATA_SIZE-1:0] win_byte;

  assign done_rise = i_tx_done & ~done_prev;

  // Rotate the request vector so bit 0 is the requester right after ptr;
  // the lowest set bit of the rotated vector is the round-robin winner.
  always_comb begin
    shift_amt = {1'b0, ptr} + (PTR_W+1)'(1);
    req_rot   = N_REQ'({i_req, i_req} >> shift_amt);
    rot_off   = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req_rot[j]) rot_off = PTR_W'(j);
    end
    win_sum = shift_amt + {1'b0, rot_off};
    if (win_sum >= (PTR_W+1)'(N_REQ)) win_sum = win_sum - (PTR_W+1)'(N_REQ);
    win_idx    = PTR_W'(win_sum);
    win_onehot = '0;
    win_byte   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win_idx == PTR_W'(k)) begin
        win_onehot[k] = 1'b1;
        win_byte      = i_data[k*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      ptr        <= PTR_W'(N_REQ - 1);
      owner      <= '0;
      cnt        <= '0;
      done_prev  <= 1'b0;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
      o_grant    <= '0;
      o_ack      <= '0;
      o_timeout  <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      done_prev <= i_tx_done;
      o_ack     <= '0;
      o_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|i_req) begin
            owner      <= win_idx;
            o_grant    <= win_onehot;
            o_tx_data  <= win_byte;
            o_tx_start <= 1'b1;
            o_busy     <= 1'b1;
            cnt        <= '0;
            state      <= START;
          end
        end
        START: begin
          if (i_tx_active) begin
            o_tx_start <= 1'b0;
            if (done_rise) begin
              // Transmitter finished within the same cycle it reported active.
              o_ack   <= o_grant;
              o_grant <= '0;
              ptr     <= owner;
              state   <= RELEASE;
            end else begin
              state <= SEND;
            end
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            o_timeout  <= 1'b1;
            o_tx_start <= 1'b0;
            o_grant    <= '0;
            o_busy     <= 1'b0;
            ptr        <= owner;
            cnt        <= '0;
            state      <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SEND: begin
          if (done_rise) begin
            o_ack   <= o_grant;
            o_grant <= '0;
            ptr     <= owner;
            state   <= RELEASE;
          end
        end
        RELEASE: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios plus randomized transactions
// checked against a round-robin reference computed from the arbitration rules.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int TMO  = 15;

  logic           clk = 1'b0;
  logic           reset;
  logic [3:0]     req;
  logic [31:0]    data;
  logic           tx_active;
  logic           tx_done;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic [3:0]     grant;
  logic [3:0]     ack;
  logic           timeout;
  logic           busy;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.DATA_SIZE(DW), .N_REQ(NREQ), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_reset(reset), .i_req(req), .i_data(data),
    .i_tx_active(tx_active), .i_tx_done(tx_done),
    .o_tx_start(tx_start), .o_tx_data(tx_data), .o_grant(grant),
    .o_ack(ack), .o_timeout(timeout), .o_busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      checks++;
      if ($countones(grant) > 1) begin
        errors++;
        $display("FAIL grant_onehot got %b required at most one bit set", grant);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_pick(input logic [3:0] r, input int last);
    for (int i = 1; i <= NREQ; i++) begin
      int k;
      k = (last + i) % NREQ;
      if (((r >> k) & 4'b0001) != 4'b0000) return k;
    end
    return -1;
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] d, input int k);
    return 8'(d >> (k * 8));
  endfunction

  task automatic do_reset;
    reset = 1'b1; req = '0; tx_active = 1'b0; tx_done = 1'b0;
    tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; req = 4'b1011; data = $urandom; tx_active = 1'b0; tx_done = 1'b0;
    tick; tick;
    checks++; if (grant !== 4'b0) begin errors++; $display("FAIL reset_grant got %b want 0000", grant); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    checks++; if (ack !== 4'b0) begin errors++; $display("FAIL reset_ack got %b want 0000", ack); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    reset = 1'b0; req = '0;
    tick;
    checks++; if (grant !== 4'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle got grant=%b busy=%b want 0000/0", grant, busy);
    end
  endtask

  task automatic test_single;
    int n, acks;
    do_reset;
    data = $urandom; data[7:0] = 8'h5A; req = 4'b0001;
    tick;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant got %b want 0001", grant); end
    checks++; if (tx_data !== 8'h5A) begin errors++; $display("FAIL single_data got %h want 5a", tx_data); end
    checks++; if (tx_start !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL single_start got start=%b busy=%b want 1/1", tx_start, busy);
    end
    repeat (2) begin
      tick;
      checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_start_hold got %b want 1", tx_start); end
    end
    tx_active = 1'b1;
    tick;
    checks++; if (tx_start !== 1'b0 || grant !== 4'b0001) begin
      errors++; $display("FAIL single_active got start=%b grant=%b want 0/0001", tx_start, grant);
    end
    req = 4'b0000; data = $urandom;
    n = $urandom_range(1, 4); acks = 0;
    repeat (n) begin tick; if (ack !== 4'b0) acks++; end
    checks++; if (acks != 0) begin errors++; $display("FAIL single_early_ack got %0d want 0", acks); end
    tx_done = 1'b1;
    tick;
    checks++; if (ack !== 4'b0001 || grant !== 4'b0 || tx_data !== 8'h5A) begin
      errors++; $display("FAIL single_ack got ack=%b grant=%b data=%h want 0001/0000/5a", ack, grant, tx_data);
    end
    tx_done = 1'b0; tx_active = 1'b0;
    tick;
    checks++; if (ack !== 4'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_release got ack=%b busy=%b want 0000/0", ack, busy);
    end
  endtask

  task automatic test_fairness;
    int order [5] = '{0, 1, 2, 3, 0};
    int n;
    do_reset;
    req = 4'b1111; data = $urandom;
    for (int t = 0; t < 5; t++) begin
      n = 0;
      while (grant === 4'b0 && n < 6) begin tick; n++; end
      checks++; if (grant !== 4'(1 << order[t])) begin
        errors++; $display("FAIL fair_grant%0d got %b want %b", t, grant, 4'(1 << order[t]));
      end
      checks++; if (n != ((t == 0) ? 1 : 2)) begin
        errors++; $display("FAIL fair_gap%0d got %0d cycles want %0d", t, n, (t == 0) ? 1 : 2);
      end
      checks++; if (tx_data !== byte_of(data, order[t])) begin
        errors++; $display("FAIL fair_data%0d got %h want %h", t, tx_data, byte_of(data, order[t]));
      end
      tx_active = 1'b1; tx_done = 1'b1;
      tick;
      checks++; if (ack !== 4'(1 << order[t])) begin
        errors++; $display("FAIL fair_ack%0d got %b want %b", t, ack, 4'(1 << order[t]));
      end
      tx_active = 1'b0; tx_done = 1'b0;
    end
    req = '0;
    tick; tick;
  endtask

  task automatic test_timeout;
    int n, cyc, acks;
    do_reset;
    data = $urandom; req = 4'b0010;
    tick;
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL to_grant got %b want 0010", grant); end
    n = 0; cyc = 0; acks = 0;
    while (timeout !== 1'b1 && cyc < 40) begin
      if (tx_start === 1'b1) n++;
      if (ack !== 4'b0) acks++;
      tick; cyc++;
    end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_pulse got %b want 1", timeout); end
    checks++; if (n != TMO) begin errors++; $display("FAIL to_cycles got %0d want %0d", n, TMO); end
    checks++; if (acks != 0 || ack !== 4'b0) begin errors++; $display("FAIL to_no_ack got %0d acks want 0", acks); end
    checks++; if (grant !== 4'b0 || tx_start !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL to_clear got grant=%b start=%b busy=%b want 0000/0/0", grant, tx_start, busy);
    end
    req = 4'b0110; data = $urandom;
    tick;
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_one_cycle got %b want 0", timeout); end
    checks++; if (grant !== 4'b0100 || tx_data !== byte_of(data, 2)) begin
      errors++; $display("FAIL to_next_grant got %b/%h want 0100/%h", grant, tx_data, byte_of(data, 2));
    end
    tx_active = 1'b1; tx_done = 1'b1;
    tick;
    checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL to_next_ack got %b want 0100", ack); end
    tx_active = 1'b0; tx_done = 1'b0; req = '0;
    tick; tick;
  endtask

  task automatic test_stale_done;
    int acks;
    do_reset;
    data = $urandom; req = 4'b0100;
    tick;
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL stale_grant got %b want 0100", grant); end
    tx_done = 1'b1;
    tick;
    checks++; if (ack !== 4'b0 || tx_start !== 1'b1) begin
      errors++; $display("FAIL stale_start got ack=%b start=%b want 0000/1", ack, tx_start);
    end
    tx_active = 1'b1;
    tick;
    checks++; if (ack !== 4'b0 || tx_start !== 1'b0) begin
      errors++; $display("FAIL stale_enter_send got ack=%b start=%b want 0000/0", ack, tx_start);
    end
    acks = 0;
    repeat ($urandom_range(2, 5)) begin tick; if (ack !== 4'b0) acks++; end
    tx_done = 1'b0;
    tick; if (ack !== 4'b0) acks++;
    checks++; if (acks != 0) begin errors++; $display("FAIL stale_level_ack got %0d acks want 0", acks); end
    tx_done = 1'b1;
    tick;
    checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL stale_fresh_ack got %b want 0100", ack); end
    req = '0; acks = 0;
    repeat (3) begin tick; if (ack !== 4'b0) acks++; end
    checks++; if (acks != 0) begin errors++; $display("FAIL stale_single_ack got %0d extra acks want 0", acks); end
    tx_done = 1'b0; tx_active = 1'b0;
    tick;
  endtask

  task automatic test_reset_in_send;
    data = $urandom; req = 4'b0001;
    tick;
    checks++; if (grant !== 4'(1 << ref_pick(4'b0001, 2))) begin
      errors++; $display("FAIL rst_send_grant got %b want 0001", grant);
    end
    tx_active = 1'b1;
    tick; tick;
    reset = 1'b1;
    tick;
    checks++; if (grant !== 4'b0 || tx_start !== 1'b0 || tx_data !== 8'h00) begin
      errors++; $display("FAIL rst_send_outputs got %b/%b/%h want 0000/0/00", grant, tx_start, tx_data);
    end
    checks++; if (ack !== 4'b0 || timeout !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_send_flags got ack=%b to=%b busy=%b want 0000/0/0", ack, timeout, busy);
    end
    reset = 1'b0; tx_active = 1'b0; req = 4'b1000; data = $urandom;
    tick;
    checks++; if (grant !== 4'b1000 || ack !== 4'b0 || timeout !== 1'b0) begin
      errors++; $display("FAIL rst_send_regrant got grant=%b ack=%b to=%b want 1000/0000/0", grant, ack, timeout);
    end
    tx_active = 1'b1; tx_done = 1'b1;
    tick;
    checks++; if (ack !== 4'b1000) begin errors++; $display("FAIL rst_send_ack got %b want 1000", ack); end
    tx_active = 1'b0; tx_done = 1'b0; req = '0;
    tick; tick;
  endtask

  task automatic test_random;
    int last, e, n, da, dd, acks, bad;
    logic [3:0] r;
    logic [7:0] eb;
    logic [3:0] eo;
    do_reset;
    last = NREQ - 1;
    for (int it = 0; it < 40; it++) begin
      r = 4'($urandom_range(1, 15));
      data = $urandom;
      e = ref_pick(r, last);
      eb = byte_of(data, e);
      eo = 4'(1 << e);
      req = r;
      n = 0;
      while (grant === 4'b0 && n < 4) begin tick; n++; end
      checks++; if (grant !== eo || n != 1) begin
        errors++; $display("FAIL rnd_grant%0d got %b after %0d want %b after 1 (req=%b)", it, grant, n, eo, r);
      end
      checks++; if (tx_data !== eb || tx_start !== 1'b1) begin
        errors++; $display("FAIL rnd_latch%0d got %h/%b want %h/1", it, tx_data, tx_start, eb);
      end
      req = 4'($urandom); data = $urandom;
      da = $urandom_range(0, 4); bad = 0;
      repeat (da) begin tick; if (tx_start !== 1'b1) bad++; end
      checks++; if (bad != 0) begin errors++; $display("FAIL rnd_start_hold%0d got %0d drops want 0", it, bad); end
      if ($urandom_range(0, 3) == 0) begin
        tx_active = 1'b1; tx_done = 1'b1;
        tick;
        checks++; if (tx_start !== 1'b0 || ack !== eo) begin
          errors++; $display("FAIL rnd_simul%0d got start=%b ack=%b want 0/%b", it, tx_start, ack, eo);
        end
      end else begin
        tx_active = 1'b1;
        tick;
        checks++; if (tx_start !== 1'b0 || ack !== 4'b0) begin
          errors++; $display("FAIL rnd_active%0d got start=%b ack=%b want 0/0000", it, tx_start, ack);
        end
        dd = $urandom_range(0, 4); acks = 0;
        repeat (dd) begin tick; if (ack !== 4'b0) acks++; end
        tx_done = 1'b1;
        tick;
        checks++; if (ack !== eo || acks != 0) begin
          errors++; $display("FAIL rnd_ack%0d got %b (early %0d) want %b", it, ack, acks, eo);
        end
      end
      checks++; if (grant !== 4'b0 || tx_data !== eb) begin
        errors++; $display("FAIL rnd_release%0d got grant=%b data=%h want 0000/%h", it, grant, tx_data, eb);
      end
      last = e;
      req = '0; tx_active = 1'b0; tx_done = 1'b0;
      tick;
      checks++; if (ack !== 4'b0 || busy !== 1'b0 || tx_data !== eb) begin
        errors++; $display("FAIL rnd_idle%0d got ack=%b busy=%b data=%h want 0000/0/%h", it, ack, busy, tx_data, eb);
      end
    end
  endtask

  initial begin
    reset = 1'b1; req = '0; data = '0; tx_active = 1'b0; tx_done = 1'b0;
    test_reset;
    test_single;
    test_fairness;
    test_timeout;
    test_stale_done;
    test_reset_in_send;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
